// File: rtl/apb_fifo_pkg.sv
// Shared types and constants for the APB-attached byte FIFO.
package apb_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [5:0] ADDR_DATA   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_CTRL   = 6'h02;

    localparam int DEF_DEPTH   = 8;
    localparam int DEF_TIMEOUT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte FIFO: storage, wrapping pointers and occupancy count.
module sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [4:0] level,
    output logic       full,
    output logic       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_level;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_level == 5'(DEPTH));
    assign empty     = (r_level == 5'd0);
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full && !flush;
    assign w_pop_ok  = pop && !empty && !flush;

    // Storage is never cleared; a flush only rewinds the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + 5'd1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_level <= r_level - 5'd1;
            end
        end
    end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB slave fronting a byte FIFO with DATA / STATUS / CTRL registers.
//
// state | meaning
// IDLE  | no transfer in progress, waiting for an access phase
// WAIT  | access blocked on full/empty FIFO, counting toward timeout
// RESP  | PREADY high for one cycle, PSLVERR/PRDATA valid
module apb_fifo_slave
    import apb_fifo_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSELECT,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [6:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    output logic [4:0] fifo_level,
    output logic       fifo_full,
    output logic       fifo_empty
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        r_state;
    logic [CW-1:0] r_wait_cnt;
    logic [7:0]    r_prdata;
    logic          r_pready;
    logic          r_pslverr;

    logic [5:0] w_addr;
    logic       w_addr_unused;
    logic       w_is_data, w_is_status, w_is_ctrl;
    logic       w_err_direct, w_ready_now;
    logic       w_commit, w_timeout, w_enter_resp, w_resp_err, w_do_op;
    logic       w_push, w_pop, w_flush;
    logic [7:0] w_fifo_rdata, w_rd_value;
    logic [4:0] w_level;
    logic       w_full, w_empty;

    assign w_addr        = PADDR[5:0];
    assign w_addr_unused = PADDR[6];

    // Address decode, serviceability and the single FIFO op for this transfer.
    always_comb begin
        w_is_data    = (w_addr == ADDR_DATA);
        w_is_status  = (w_addr == ADDR_STATUS);
        w_is_ctrl    = (w_addr == ADDR_CTRL);
        // Unmapped addresses and STATUS writes error without ever waiting.
        w_err_direct = !(w_is_data || w_is_status || w_is_ctrl) || (w_is_status && PWRITE);
        w_ready_now  = !w_is_data || (PWRITE ? !w_full : !w_empty);

        w_commit     = ((r_state == ST_IDLE) && PSELECT && PENABLE && w_ready_now)
                    || ((r_state == ST_WAIT) && PSELECT && w_ready_now);
        w_timeout    = (r_state == ST_WAIT) && PSELECT && !w_ready_now
                    && (r_wait_cnt == CW'(TIMEOUT - 1));
        w_enter_resp = w_commit || w_timeout;
        w_resp_err   = w_timeout || (w_commit && w_err_direct);
        w_do_op      = w_commit && !w_err_direct;

        w_push  = w_do_op && w_is_data && PWRITE;
        w_pop   = w_do_op && w_is_data && !PWRITE;
        w_flush = w_do_op && w_is_ctrl && PWRITE && PWDATA[0];

        w_rd_value = 8'h00;
        if (w_is_data) begin
            w_rd_value = w_fifo_rdata;
        end else if (w_is_status) begin
            w_rd_value = {1'b0, w_full, w_empty, w_level};
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk (PCLK),
        .i_rst (PRESET),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (PWDATA),
        .rdata (w_fifo_rdata),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    // Transfer sequencing with registered response outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= 8'h00;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (PSELECT && PENABLE && !w_ready_now) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!PSELECT) begin
                        r_state <= ST_IDLE;
                    end else if (!w_enter_resp) begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_enter_resp) begin
                r_state   <= ST_RESP;
                r_pready  <= 1'b1;
                r_pslverr <= w_resp_err;
                if (w_resp_err) begin
                    r_prdata <= 8'h00;
                end else if (!PWRITE) begin
                    r_prdata <= w_rd_value;
                end
            end
        end
    end

    assign PRDATA     = r_prdata;
    assign PREADY     = r_pready;
    assign PSLVERR    = r_pslverr;
    assign fifo_level = w_level;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Scoreboard bench for apb_fifo_slave: driver pushes expectations from a
// queue-based model, a monitor pops and checks on every PREADY.
module tb_apb_fifo_slave;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 4;

    logic       PCLK, PRESET, PSELECT, PENABLE, PWRITE;
    logic [6:0] PADDR;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR;
    logic [4:0] fifo_level;
    logic       fifo_full, fifo_empty;

    typedef struct {
        string      name;
        bit         err;
        bit         chk_data;
        logic [7:0] data;
        int         stall;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] q[$];
    int         total = 0;
    int         bad = 0;

    apb_fifo_slave #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .PSELECT    (PSELECT),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    function automatic int status_of();
        return (q.size() == DEPTH ? 64 : 0) + (q.size() == 0 ? 32 : 0) + q.size();
    endfunction

    task automatic check_side(input string nm);
        chk({nm, "_level"}, 32'(fifo_level), 32'(q.size()));
        chk({nm, "_full"},  32'(fifo_full),  32'(q.size() == DEPTH));
        chk({nm, "_empty"}, 32'(fifo_empty), 32'(q.size() == 0));
    endtask

    // Model the transfer, queue its expected response, then run it on the bus.
    task automatic xfer(input bit wr, input logic [6:0] addr, input logic [7:0] wd, input string nm);
        exp_t       e;
        int         n;
        logic [5:0] a;
        a = addr[5:0];
        e.name = nm; e.err = 1'b0; e.chk_data = 1'b0; e.data = 8'h00; e.stall = 0;
        if (a > 6'h02 || (a == 6'h01 && wr)) begin
            e.err = 1'b1; e.chk_data = 1'b1;
        end else if (a == 6'h00) begin
            if (wr) begin
                if (q.size() < DEPTH) q.push_back(wd);
                else begin e.err = 1'b1; e.chk_data = 1'b1; e.stall = TIMEOUT; end
            end else begin
                e.chk_data = 1'b1;
                if (q.size() > 0) e.data = q.pop_front();
                else begin e.err = 1'b1; e.stall = TIMEOUT; end
            end
        end else if (a == 6'h01) begin
            e.chk_data = 1'b1;
            e.data = 8'(status_of());
        end else begin
            if (wr) begin
                if (wd[0]) q.delete();
            end else begin
                e.chk_data = 1'b1;
            end
        end
        sb.push_back(e);

        @(negedge PCLK);
        PSELECT = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PREADY && n < 40);
        chk({nm, "_pready_seen"}, 32'(PREADY), 32'd1);
        PSELECT = 1'b0; PENABLE = 1'b0;
        check_side(nm);
    endtask

    // Start a transfer that will block, then walk away (or reset) mid-WAIT.
    task automatic abandon(input bit wr, input logic [6:0] addr, input logic [7:0] wd, input bit use_reset, input string nm);
        @(negedge PCLK);
        PSELECT = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        repeat (2) @(negedge PCLK);
        PSELECT = 1'b0; PENABLE = 1'b0;
        if (use_reset) begin
            PRESET = 1'b1;
            q.delete();
            @(negedge PCLK);
            PRESET = 1'b0;
        end
        repeat (6) @(negedge PCLK);
        chk({nm, "_no_pready"}, 32'(PREADY), 32'd0);
        check_side(nm);
    endtask

    // Monitor: stall = access-phase samples with PREADY low before the response.
    initial begin
        int   stall;
        exp_t e;
        stall = 0;
        forever begin
            @(posedge PCLK);
            #1;
            if (PRESET) begin
                stall = 0;
            end else if (PREADY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pready", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_pslverr"}, 32'(PSLVERR), 32'(e.err));
                    chk({e.name, "_stall"}, 32'(stall), 32'(e.stall));
                    if (e.chk_data) chk({e.name, "_prdata"}, 32'(PRDATA), 32'(e.data));
                end
                stall = 0;
            end else begin
                if (PSLVERR) chk("pslverr_outside_resp", 32'(PSLVERR), 32'd0);
                if (PSELECT && PENABLE) stall++;
                else stall = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a;
        logic [7:0] d;
        bit         wr;
        int         sel;

        PRESET = 1'b1; PSELECT = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 7'h00; PWDATA = 8'h00;
        repeat (3) @(negedge PCLK);
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_prdata", 32'(PRDATA), 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check_side("rst");

        // In-order readback.
        xfer(1'b1, 7'h00, 8'h11, "push11");
        xfer(1'b1, 7'h00, 8'h22, "push22");
        xfer(1'b1, 7'h00, 8'h33, "push33");
        repeat (3) xfer(1'b0, 7'h00, 8'h00, "pop_fifo_order");

        // Fill, status when full, blocked push times out.
        for (int i = 0; i < DEPTH; i++) xfer(1'b1, 7'h00, 8'(8'hA0 + i), "fill");
        xfer(1'b0, 7'h01, 8'h00, "status_full");
        xfer(1'b1, 7'h00, 8'hEE, "push_when_full");
        for (int i = 0; i < DEPTH; i++) xfer(1'b0, 7'h00, 8'h00, "drain");

        // Read on empty times out; abandoned read leaves no trace.
        xfer(1'b0, 7'h00, 8'h00, "pop_when_empty");
        abandon(1'b0, 7'h00, 8'h00, 1'b0, "abandon_read");
        xfer(1'b0, 7'h01, 8'h00, "status_after_abandon");

        // Flush, then wrap the pointers.
        for (int i = 0; i < 5; i++) xfer(1'b1, 7'h00, 8'(8'h50 + i), "pre_flush");
        xfer(1'b1, 7'h02, 8'h01, "ctrl_flush");
        xfer(1'b0, 7'h01, 8'h00, "status_after_flush");
        xfer(1'b0, 7'h02, 8'h00, "ctrl_read");
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            xfer(1'b1, 7'h00, d, "wrap_push");
            xfer(1'b0, 7'h00, 8'h00, "wrap_pop");
        end

        // Error decodes; PADDR[6] ignored.
        xfer(1'b1, 7'h00, 8'h77, "push77");
        xfer(1'b0, 7'h45, 8'h00, "unmapped_rd_45");
        xfer(1'b1, 7'h45, 8'h99, "unmapped_wr_45");
        xfer(1'b1, 7'h01, 8'hFF, "status_write");
        xfer(1'b0, 7'h40, 8'h00, "pop_alias_40");

        // Reset pulse while a push is stuck in WAIT.
        for (int i = 0; i < DEPTH; i++) xfer(1'b1, 7'h00, 8'(8'hC0 + i), "fill2");
        abandon(1'b1, 7'h00, 8'h5A, 1'b1, "reset_in_wait");
        chk("post_rst_prdata", 32'(PRDATA), 32'd0);
        xfer(1'b1, 7'h00, 8'h3C, "push_after_rst");
        xfer(1'b0, 7'h00, 8'h00, "pop_after_rst");

        // Randomized mix.
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            wr  = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            a[6] = 1'($urandom_range(0, 1));
            if (sel <= 5) a[5:0] = 6'h00;
            else if (sel <= 7) a[5:0] = 6'h01;
            else if (sel == 8) begin
                a[5:0] = 6'h02;
                d[0] = ($urandom_range(0, 3) == 0);
            end else a[5:0] = 6'($urandom_range(3, 63));
            xfer(wr, a, d, "rand");
        end

        repeat (4) @(negedge PCLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
